// File: rtl/neuron_layer_loader.sv
// Purpose: replays a counted burst from a valid/ready stream as single-cycle layer writes with an auto-incrementing, wrapping address.
// Latency: a beat accepted at edge k appears on load_en/load_value/load_address in cycle k+1; throughput is 1 value/cycle.
// Backpressure: in_ready is high only in LOAD and never depends on in_valid; upstream may stall freely between beats.
//
// Ports:
//   clk, reset        - single clock; asynchronous active-low reset
//   start             - burst request, sampled only in IDLE with base_address and count
//   in_valid/in_data  - upstream value stream; in_ready is returned to it
//   load_en/value/address - one-cycle write strobe and payload to the neuron layer
//   busy, done, error - status: not-IDLE, end-of-burst pulse, rejected-start pulse
//
// Build option: define NEURON_LOADER_BOUNDS_CHECK_EN to reject out-of-range starts
// (base_address >= LAYER_SZ or count > LAYER_SZ). Without it, error is tied 0,
// an out-of-range base is replaced by 0 and long bursts wrap over the layer.

module neuron_layer_loader #(
   parameter int SIZE     = 16,
   parameter int LAYER_SZ = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [SIZE-1:0] base_address,
   input  logic [SIZE-1:0] count,
   input  logic            in_valid,
   input  logic [SIZE-1:0] in_data,
   output logic            in_ready,
   output logic            load_en,
   output logic [SIZE-1:0] load_value,
   output logic [SIZE-1:0] load_address,
   output logic            busy,
   output logic            done,
   output logic            error
);

   // Address datapath is only as wide as the layer needs, never narrower than 1 bit.
   localparam int                ADDR_W     = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAYER_SZ - 1);
   localparam logic [SIZE-1:0]   LAYER_SZ_W = SIZE'(LAYER_SZ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] start_addr;
   logic [SIZE-1:0]   remaining;
   logic [SIZE-1:0]   remaining_nxt;
   logic              accept;
   logic              base_oob;
   logic              start_reject;

   assign base_oob = (base_address >= LAYER_SZ_W);

`ifdef NEURON_LOADER_BOUNDS_CHECK_EN
   assign start_reject = base_oob | (count > LAYER_SZ_W);
`else
   assign start_reject = 1'b0;
`endif

   // With the check compiled out an out-of-range base falls back to neuron 0;
   // with it compiled in such a start never reaches LOAD, so the mux is harmless.
   assign start_addr = base_oob ? '0 : base_address[ADDR_W-1:0];

   // Explicit wrap so non-power-of-two layer sizes are handled correctly.
   assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

   assign accept = in_valid & in_ready;

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         remaining <= remaining_nxt;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      remaining_nxt = remaining;
      in_ready      = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && !start_reject) begin
               if (count == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt     = LOAD;
                  addr_nxt      = start_addr;
                  remaining_nxt = count;
               end
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               remaining_nxt = remaining - SIZE'(1);
               addr_nxt      = addr_inc;
               if (remaining == SIZE'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Write port: registered one cycle behind the accept; payload holds between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_en      <= 1'b0;
         load_value   <= '0;
         load_address <= '0;
      end else begin
         load_en <= accept;
         if (accept) begin
            load_value   <= in_data;
            load_address <= SIZE'(addr);
         end
      end
   end

`ifdef NEURON_LOADER_BOUNDS_CHECK_EN
   logic error_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= (state == IDLE) && start && start_reject;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_layer_loader.sv
// Purpose: scoreboard bench for neuron_layer_loader with directed bursts and hand-computed writes.
// Latency: expected events are queued at stimulus time and popped by a negedge monitor.
// Backpressure: beats wait on in_ready with a bounded cycle budget.

module tb_neuron_layer_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] base_address;
   logic [15:0] count;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        load_en;
   logic [15:0] load_value;
   logic [15:0] load_address;
   logic        busy;
   logic        done;
   logic        error;

   neuron_layer_loader #(.SIZE(16), .LAYER_SZ(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_address (base_address),
      .count        (count),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .load_en      (load_en),
      .load_value   (load_value),
      .load_address (load_address),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic        dn;
      logic        er;
      logic [15:0] addr;
      logic [15:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t mon_act;
   ev_t mon_exp;

   // Monitor: every strobe/done/error cycle must match the head of the queue.
   always @(negedge clk) begin
      if (reset && (load_en || done || error)) begin
         mon_act = '{load_en, done, error, load_address, load_value};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event at %0t: got en=%0b done=%0b err=%0b addr=%0h val=%0h, required none",
                     $time, mon_act.en, mon_act.dn, mon_act.er, mon_act.addr, mon_act.val);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act.en !== mon_exp.en || mon_act.dn !== mon_exp.dn || mon_act.er !== mon_exp.er ||
                (mon_exp.en && (mon_act.addr !== mon_exp.addr || mon_act.val !== mon_exp.val))) begin
               n_bad++;
               $display("FAIL event at %0t: got en=%0b done=%0b err=%0b addr=%0h val=%0h, required en=%0b done=%0b err=%0b addr=%0h val=%0h",
                        $time, mon_act.en, mon_act.dn, mon_act.er, mon_act.addr, mon_act.val,
                        mon_exp.en, mon_exp.dn, mon_exp.er, mon_exp.addr, mon_exp.val);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [15:0] v, input logic last);
      exp_q.push_back('{1'b1, last, 1'b0, a, v});
   endtask

   task automatic do_start(input logic [15:0] b, input logic [15:0] c);
      start        = 1'b1;
      base_address = b;
      count        = c;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] d);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat_timeout: in_ready never rose for data %0h, required 1", d);
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load_en"},      {31'd0, load_en},  32'd0);
      chk({tag, "_load_value"},   {16'd0, load_value},   32'd0);
      chk({tag, "_load_address"}, {16'd0, load_address}, 32'd0);
      chk({tag, "_in_ready"},     {31'd0, in_ready}, 32'd0);
      chk({tag, "_busy"},         {31'd0, busy},     32'd0);
      chk({tag, "_done"},         {31'd0, done},     32'd0);
      chk({tag, "_error"},        {31'd0, error},    32'd0);
   endtask

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      base_address = '0;
      count        = '0;
      in_valid     = 1'b0;
      in_data      = '0;
      #2;
      chk_all_zero("reset_init");
      #10 reset = 1'b1;
      tick();

      // Basic burst: (0,8000) then (1,0008) back-to-back, done with the second write.
      do_start(16'd0, 16'd2);
      chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
      push_wr(16'd0, 16'h8000, 1'b0);
      send_beat(16'h8000);
      push_wr(16'd1, 16'h0008, 1'b1);
      send_beat(16'h0008);
      chk("basic_busy_on_done", {31'd0, busy}, 32'd1);
      tick();
      chk("basic_busy_after", {31'd0, busy}, 32'd0);

      // Stalled stream with address wrap 1 -> 0.
      do_start(16'd1, 16'd2);
      push_wr(16'd1, 16'h1111, 1'b0);
      send_beat(16'h1111);
      repeat (3) tick();
      push_wr(16'd0, 16'h0008, 1'b1);
      send_beat(16'h0008);
      tick();
      chk("stall_busy_after", {31'd0, busy}, 32'd0);

      // count=0: done one cycle after start, no write.
      exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'd0, 16'd0});
      do_start(16'd0, 16'd0);
      chk("cnt0_done", {31'd0, done}, 32'd1);
      tick();
      chk("cnt0_busy_after", {31'd0, busy}, 32'd0);

      // start pulsed during LOAD is ignored.
      do_start(16'd0, 16'd2);
      start        = 1'b1;
      base_address = 16'd1;
      count        = 16'd0;
      push_wr(16'd0, 16'hA5A5, 1'b0);
      send_beat(16'hA5A5);
      start = 1'b0;
      push_wr(16'd1, 16'h5A5A, 1'b1);
      send_beat(16'h5A5A);
      tick();
      chk("ign_busy_after", {31'd0, busy}, 32'd0);

      // Reset mid-burst: one write, then async reset drops the pending beat.
      do_start(16'd0, 16'd2);
      push_wr(16'd0, 16'hCAFE, 1'b0);
      send_beat(16'hCAFE);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      #2 reset = 1'b0;
      #1;
      chk_all_zero("reset_mid");
      in_valid = 1'b0;
      repeat (2) tick();
      #2 reset = 1'b1;
      tick();
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
      do_start(16'd1, 16'd1);
      push_wr(16'd1, 16'h0777, 1'b1);
      send_beat(16'h0777);
      tick();

      // Out-of-range base.
`ifdef NEURON_LOADER_BOUNDS_CHECK_EN
      exp_q.push_back('{1'b0, 1'b0, 1'b1, 16'd0, 16'd0});
      do_start(16'd2, 16'd1);
      chk("bounds_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bounds_busy", {31'd0, busy}, 32'd0);
`else
      do_start(16'd2, 16'd1);
      chk("bounds_in_ready", {31'd0, in_ready}, 32'd1);
      push_wr(16'd0, 16'h0101, 1'b1);
      send_beat(16'h0101);
      tick();
`endif

      repeat (4) tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
